// File: rtl/snn_load_pkg.sv
// rtl/snn_load_pkg.sv - shared types, default widths and read-credit helpers for the SNN load sequencer
package snn_load_pkg;

    localparam int ADDR_W = 12;
    localparam int FILT_W = 13;
    localparam int TS_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        START_TOK,
        FILT,
        IFM,
        DONE_TOK
    } load_state_t;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
        logic              data;
    } ifm_word_t;

    // A read issued now lands in the buffer two edges from now; it may only go out if the
    // buffer is guaranteed a free slot then, counting the read already in flight.
    function automatic logic credit_ok(input logic [1:0] count, input logic pend, input logic pop);
        return ({1'b0, count} + {2'b00, pend}) <= ({2'b00, pop} + 3'd1);
    endfunction

    function automatic logic drained(input logic [1:0] count, input logic pop);
        return (count == 2'd0) || ((count == 2'd1) && pop);
    endfunction

endpackage

// File: rtl/snn_skid_buf.sv
// rtl/snn_skid_buf.sv - 2-entry valid/ready FIFO decoupling memory read latency from the output handshake
module snn_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? mem1_q : mem0_q;
    assign count     = count_q;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = in_valid && (count_q != 2'd2);
        pop      = out_valid && out_ready;
        if (push) begin
            if (wr_ptr_q) begin
                mem1_d = in_data;
            end else begin
                mem0_d = in_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snn_load_sequencer.sv
// rtl/snn_load_sequencer.sv - sequences load_start, filter words, ifmap spikes per timestep and load_done
module snn_load_sequencer #(
    parameter int ADDR_W   = snn_load_pkg::ADDR_W,
    parameter int FILT_W   = snn_load_pkg::FILT_W,
    parameter int TS_W     = snn_load_pkg::TS_W,
    parameter int N_FILTER = 25,
    parameter int N_IFMAP  = 1024,
    parameter int NUM_TS   = 2,
    parameter int SPARSE   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   filt_rd_en,
    output logic [ADDR_W-1:0]      filt_rd_addr,
    input  logic [FILT_W-1:0]      filt_rd_data,
    output logic                   ifm_rd_en,
    output logic [TS_W+ADDR_W-1:0] ifm_rd_addr,
    input  logic                   ifm_rd_data,
    output logic                   ls_valid,
    input  logic                   ls_ready,
    output logic                   f_valid,
    input  logic                   f_ready,
    output logic [ADDR_W-1:0]      f_addr,
    output logic [FILT_W-1:0]      f_data,
    output logic                   i_valid,
    input  logic                   i_ready,
    output logic [ADDR_W-1:0]      i_addr,
    output logic                   i_data,
    output logic [TS_W-1:0]        i_ts,
    output logic                   ld_valid,
    input  logic                   ld_ready
);
    import snn_load_pkg::*;

    localparam int FW = ADDR_W + FILT_W;
    localparam int IW = TS_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] F_LAST  = ADDR_W'(N_FILTER - 1);
    localparam logic [ADDR_W-1:0] I_LAST  = ADDR_W'(N_IFMAP - 1);
    localparam logic [TS_W-1:0]   TS_LAST = TS_W'(NUM_TS - 1);

    load_state_t       state_q, state_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] f_cnt_q, f_cnt_d;
    logic              f_all_q, f_all_d;
    logic              f_pend_q, f_pend_d;
    logic [ADDR_W-1:0] f_pend_addr_q, f_pend_addr_d;

    logic [ADDR_W-1:0] i_cnt_q, i_cnt_d;
    logic [TS_W-1:0]   i_ts_cnt_q, i_ts_cnt_d;
    logic              i_all_q, i_all_d;
    logic              i_pend_q, i_pend_d;
    logic [ADDR_W-1:0] i_pend_addr_q, i_pend_addr_d;
    logic [TS_W-1:0]   i_pend_ts_q, i_pend_ts_d;

    logic [1:0]        f_count, i_count;
    logic              f_pop, i_pop;
    logic              i_wr;
    logic [FW-1:0]     f_buf_data;
    logic [IW-1:0]     i_buf_data;

    snn_skid_buf #(.W(FW)) u_filt_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (f_pend_q),
        .in_data   ({f_pend_addr_q, filt_rd_data}),
        .out_valid (f_valid),
        .out_ready (f_ready),
        .out_data  (f_buf_data),
        .count     (f_count)
    );

    // Zero spikes are discarded here when sparse, after the read has already been paid for.
    assign i_wr = i_pend_q && ((SPARSE == 0) || ifm_rd_data);

    snn_skid_buf #(.W(IW)) u_ifm_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (i_wr),
        .in_data   ({i_pend_ts_q, i_pend_addr_q, ifm_rd_data}),
        .out_valid (i_valid),
        .out_ready (i_ready),
        .out_data  (i_buf_data),
        .count     (i_count)
    );

    assign {f_addr, f_data}       = f_buf_data;
    assign {i_ts, i_addr, i_data} = i_buf_data;
    assign f_pop        = f_valid && f_ready;
    assign i_pop        = i_valid && i_ready;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign ls_valid     = (state_q == START_TOK);
    assign ld_valid     = (state_q == DONE_TOK);
    assign filt_rd_addr = f_cnt_q;
    assign ifm_rd_addr  = {i_ts_cnt_q, i_cnt_q};

    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        f_cnt_d       = f_cnt_q;
        f_all_d       = f_all_q;
        f_pend_d      = 1'b0;
        f_pend_addr_d = f_pend_addr_q;
        i_cnt_d       = i_cnt_q;
        i_ts_cnt_d    = i_ts_cnt_q;
        i_all_d       = i_all_q;
        i_pend_d      = 1'b0;
        i_pend_addr_d = i_pend_addr_q;
        i_pend_ts_d   = i_pend_ts_q;
        filt_rd_en    = 1'b0;
        ifm_rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START_TOK;
                    f_cnt_d    = '0;
                    f_all_d    = 1'b0;
                    i_cnt_d    = '0;
                    i_ts_cnt_d = '0;
                    i_all_d    = 1'b0;
                end
            end
            START_TOK: begin
                if (ls_ready) begin
                    state_d = FILT;
                end
            end
            FILT: begin
                if (!f_all_q && credit_ok(f_count, f_pend_q, f_pop)) begin
                    filt_rd_en    = 1'b1;
                    f_pend_d      = 1'b1;
                    f_pend_addr_d = f_cnt_q;
                    if (f_cnt_q == F_LAST) begin
                        f_all_d = 1'b1;
                    end else begin
                        f_cnt_d = f_cnt_q + 1'b1;
                    end
                end
                if (f_all_q && !f_pend_q && drained(f_count, f_pop)) begin
                    state_d = IFM;
                end
            end
            IFM: begin
                if (!i_all_q && credit_ok(i_count, i_pend_q, i_pop)) begin
                    ifm_rd_en     = 1'b1;
                    i_pend_d      = 1'b1;
                    i_pend_addr_d = i_cnt_q;
                    i_pend_ts_d   = i_ts_cnt_q;
                    if (i_cnt_q == I_LAST) begin
                        i_cnt_d = '0;
                        if (i_ts_cnt_q == TS_LAST) begin
                            i_all_d = 1'b1;
                        end else begin
                            i_ts_cnt_d = i_ts_cnt_q + 1'b1;
                        end
                    end else begin
                        i_cnt_d = i_cnt_q + 1'b1;
                    end
                end
                if (i_all_q && !i_pend_q && drained(i_count, i_pop)) begin
                    state_d = DONE_TOK;
                end
            end
            DONE_TOK: begin
                if (ld_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            f_cnt_q       <= '0;
            f_all_q       <= 1'b0;
            f_pend_q      <= 1'b0;
            f_pend_addr_q <= '0;
            i_cnt_q       <= '0;
            i_ts_cnt_q    <= '0;
            i_all_q       <= 1'b0;
            i_pend_q      <= 1'b0;
            i_pend_addr_q <= '0;
            i_pend_ts_q   <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            f_cnt_q       <= f_cnt_d;
            f_all_q       <= f_all_d;
            f_pend_q      <= f_pend_d;
            f_pend_addr_q <= f_pend_addr_d;
            i_cnt_q       <= i_cnt_d;
            i_ts_cnt_q    <= i_ts_cnt_d;
            i_all_q       <= i_all_d;
            i_pend_q      <= i_pend_d;
            i_pend_addr_q <= i_pend_addr_d;
            i_pend_ts_q   <= i_pend_ts_d;
        end
    end

endmodule

// File: tb/tb_snn_load_sequencer.sv
// tb/tb_snn_load_sequencer.sv - scoreboard bench for snn_load_sequencer, dense and sparse instances
module tb_snn_load_sequencer;

    localparam int NF = 4;
    localparam int NI = 8;
    localparam int NT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start        [2];
    logic        busy         [2];
    logic        done         [2];
    logic        filt_rd_en   [2];
    logic [11:0] filt_rd_addr [2];
    logic [12:0] filt_rd_data [2];
    logic        ifm_rd_en    [2];
    logic [13:0] ifm_rd_addr  [2];
    logic        ifm_rd_data  [2];
    logic        ls_valid     [2];
    logic        ls_ready     [2];
    logic        f_valid      [2];
    logic        f_ready      [2];
    logic [11:0] f_addr       [2];
    logic [12:0] f_data       [2];
    logic        i_valid      [2];
    logic        i_ready      [2];
    logic [11:0] i_addr       [2];
    logic        i_data       [2];
    logic [1:0]  i_ts         [2];
    logic        ld_valid     [2];
    logic        ld_ready     [2];

    snn_load_sequencer #(.N_FILTER(NF), .N_IFMAP(NI), .NUM_TS(NT), .SPARSE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .filt_rd_en(filt_rd_en[0]), .filt_rd_addr(filt_rd_addr[0]), .filt_rd_data(filt_rd_data[0]),
        .ifm_rd_en(ifm_rd_en[0]), .ifm_rd_addr(ifm_rd_addr[0]), .ifm_rd_data(ifm_rd_data[0]),
        .ls_valid(ls_valid[0]), .ls_ready(ls_ready[0]),
        .f_valid(f_valid[0]), .f_ready(f_ready[0]), .f_addr(f_addr[0]), .f_data(f_data[0]),
        .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_addr(i_addr[0]), .i_data(i_data[0]), .i_ts(i_ts[0]),
        .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0])
    );

    snn_load_sequencer #(.N_FILTER(NF), .N_IFMAP(NI), .NUM_TS(NT), .SPARSE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .filt_rd_en(filt_rd_en[1]), .filt_rd_addr(filt_rd_addr[1]), .filt_rd_data(filt_rd_data[1]),
        .ifm_rd_en(ifm_rd_en[1]), .ifm_rd_addr(ifm_rd_addr[1]), .ifm_rd_data(ifm_rd_data[1]),
        .ls_valid(ls_valid[1]), .ls_ready(ls_ready[1]),
        .f_valid(f_valid[1]), .f_ready(f_ready[1]), .f_addr(f_addr[1]), .f_data(f_data[1]),
        .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_addr(i_addr[1]), .i_data(i_data[1]), .i_ts(i_ts[1]),
        .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1])
    );

    // Host memories shared by both instances; only one instance runs at a time.
    logic [12:0] filt_mem [NF];
    logic        ifm_mem  [NT*NI];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (filt_rd_en[d]) filt_rd_data[d] <= filt_mem[filt_rd_addr[d][1:0]];
            if (ifm_rd_en[d])  ifm_rd_data[d]  <= ifm_mem[{ifm_rd_addr[d][12], ifm_rd_addr[d][2:0]}];
        end
    end

    int   rdy_mode  = 0;
    logic ld_rdy_en = 1'b1;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            ls_ready[d] = 1'b1;
            f_ready[d]  = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            i_ready[d]  = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            ld_ready[d] = ld_rdy_en;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q [$];

    function automatic logic [31:0] ev(input int inst, input int kind, input int ts, input int addr, input int data);
        return {1'b0, 1'(inst), 3'(kind), 2'(ts), 12'(addr), 13'(data)};
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic got(input string nm, input logic [31:0] e);
        logic [31:0] x;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected got=%h exp=none", nm, e);
        end else begin
            x = exp_q.pop_front();
            if (x !== e) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", nm, e, x);
            end
        end
    endtask

    function automatic logic [79:0] outs(input int d);
        return {6'b0, busy[d], done[d], filt_rd_en[d], filt_rd_addr[d], ifm_rd_en[d], ifm_rd_addr[d],
                ls_valid[d], f_valid[d], f_addr[d], f_data[d], i_valid[d], i_addr[d], i_data[d],
                i_ts[d], ld_valid[d]};
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks payload stability under stall.
    logic        f_stall [2];
    logic        i_stall [2];
    logic [24:0] f_hold  [2];
    logic [14:0] i_hold  [2];
    int ls_cyc = -1, first_f_cyc = -1, first_i_cyc = -1, last_i_cyc = -1, n_i = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                f_stall[d] = 1'b0;
                i_stall[d] = 1'b0;
            end else begin
                if (f_stall[d]) chk("f_stable", {f_valid[d], f_addr[d], f_data[d]}, {1'b1, f_hold[d]});
                if (i_stall[d]) chk("i_stable", {i_valid[d], i_ts[d], i_addr[d], i_data[d]}, {1'b1, i_hold[d]});
                if (ls_valid[d] && ls_ready[d]) begin
                    got("ls", ev(d, 1, 0, 0, 0));
                    ls_cyc = cyc;
                end
                if (f_valid[d] && first_f_cyc < 0 && ls_cyc >= 0) first_f_cyc = cyc;
                if (f_valid[d] && f_ready[d]) got("f_word", ev(d, 2, 0, f_addr[d], f_data[d]));
                if (i_valid[d] && i_ready[d]) begin
                    got("i_word", ev(d, 3, i_ts[d], i_addr[d], i_data[d]));
                    if (n_i == 0) first_i_cyc = cyc;
                    last_i_cyc = cyc;
                    n_i++;
                end
                if (ld_valid[d] && ld_ready[d]) got("ld", ev(d, 4, 0, 0, 0));
                if (done[d]) got("done", ev(d, 5, 0, 0, 0));
                f_stall[d] = f_valid[d] && !f_ready[d];
                i_stall[d] = i_valid[d] && !i_ready[d];
                f_hold[d]  = {f_addr[d], f_data[d]};
                i_hold[d]  = {i_ts[d], i_addr[d], i_data[d]};
            end
        end
    end

    // Reference: the full token/word sequence one load must produce, from the memory contents.
    task automatic push_load(input int d);
        exp_q.push_back(ev(d, 1, 0, 0, 0));
        for (int a = 0; a < NF; a++) exp_q.push_back(ev(d, 2, 0, a, filt_mem[a]));
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < NI; a++)
                if (d == 0 || ifm_mem[t*NI+a]) exp_q.push_back(ev(d, 3, t, a, ifm_mem[t*NI+a]));
        exp_q.push_back(ev(d, 4, 0, 0, 0));
        exp_q.push_back(ev(d, 5, 0, 0, 0));
    endtask

    task automatic fill_mem();
        for (int a = 0; a < NF; a++) filt_mem[a] = 13'($urandom);
        for (int a = 0; a < NT*NI; a++) ifm_mem[a] = 1'($urandom_range(0, 1));
    endtask

    task automatic run_load(input int d, input int mode, input bit extra_start, input bit abort, input bit ld_hold);
        int n, gap, hold;
        rdy_mode  = mode;
        ld_rdy_en = !ld_hold;
        exp_q.delete();
        push_load(d);
        ls_cyc = -1; first_f_cyc = -1; n_i = 0;
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        n = 0; gap = 0; hold = 0;
        while (n < 4000) begin
            if (done[d]) break;
            if (abort && i_valid[d]) break;
            if (!busy[d]) gap++;
            start[d] = (extra_start && (n == 6 || n == 7));
            if (ld_valid[d] && !ld_rdy_en) begin
                hold++;
                chk("ld_hold", {ld_valid[d], busy[d], done[d]}, 3'b110);
                if (hold == 20) ld_rdy_en = 1'b1;
            end
            @(negedge clk); n++;
        end
        start[d] = 1'b0;
        if (abort) begin
            chk("abort_reached", i_valid[d], 1'b1);
            reset = 1'b1;
            @(negedge clk);
            chk("reset_mid_ifm", outs(d), '0);
            @(posedge clk); #1;
            reset = 1'b0;
            exp_q.delete();
        end else begin
            chk("load_timeout", done[d], 1'b1);
            chk("busy_gap", gap, 0);
            if (ld_hold) chk("ld_hold_len", hold, 20);
            @(negedge clk);
            chk("done_pulse", done[d], 1'b0);
            chk("sb_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        logic [7:0] pat;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; filt_rd_data[d] = '0; ifm_rd_data[d] = 1'b0;
            f_stall[d] = 1'b0; i_stall[d] = 1'b0;
        end
        fill_mem();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("reset_state", outs(d), '0);
        reset = 1'b0;
        @(negedge clk);

        run_load(0, 0, 0, 0, 0);
        chk("f_latency", first_f_cyc - ls_cyc, 3);
        chk("i_count", n_i, 16);
        chk("i_throughput", last_i_cyc - first_i_cyc, 15);

        run_load(0, 1, 0, 0, 0);
        fill_mem();
        run_load(0, 1, 0, 0, 0);

        pat = 8'b1000_0101;
        for (int a = 0; a < NI; a++) begin
            ifm_mem[a]    = pat[a];
            ifm_mem[NI+a] = 1'b0;
        end
        run_load(1, 0, 0, 0, 0);
        chk("sparse_count", n_i, 3);
        fill_mem();
        run_load(1, 1, 0, 0, 0);
        for (int a = 0; a < NT*NI; a++) ifm_mem[a] = 1'b0;
        run_load(1, 0, 0, 0, 0);
        chk("sparse_none", n_i, 0);

        fill_mem();
        run_load(0, 1, 1, 0, 0);

        reset = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0; start[0] = 1'b0;
        @(negedge clk);
        chk("start_with_reset", {busy[0], ls_valid[0]}, 2'b00);

        run_load(0, 0, 0, 1, 0);
        run_load(0, 0, 0, 0, 0);
        run_load(0, 1, 0, 1, 0);
        run_load(0, 1, 0, 0, 0);

        run_load(0, 1, 0, 0, 1);
        run_load(1, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
